// File: rtl/adc_cfg_seq_if.sv
// Write handshake between the ADC configuration sequencer and the SPI master.
interface adc_cfg_seq_if;
    logic        writ_flag;
    logic [31:0] writ_data;
    logic        rdy;

    modport master (output writ_flag, output writ_data, input rdy);
    modport slave  (input writ_flag, input writ_data, output rdy);
endinterface

// File: rtl/adc_cfg_seq.sv
// Walks cfg_table and hands each word to the SPI master, with a gap after each transfer.
// Optional soft-reset word ahead of the table: define ADC_CFG_SOFT_RESET_EN.
module adc_cfg_seq #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1023,
    parameter logic [31:0] RST_WORD   = 32'h0000_0081,
    parameter int unsigned RST_WAIT   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_REGS*32-1:0]        cfg_table,
    adc_cfg_seq_if.master                 spi,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(NUM_REGS+1)-1:0] err_idx
);
    localparam int unsigned IW       = $clog2(NUM_REGS + 1);
    localparam int unsigned WAIT_MAX = (TIMEOUT > RST_WAIT) ? TIMEOUT : RST_WAIT;
    localparam int unsigned CNT_MAX  = (WAIT_MAX > GAP_CYCLES) ? WAIT_MAX : GAP_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    // Index NUM_REGS denotes the soft-reset word.
    localparam logic [IW-1:0] RST_IDX  = IW'(NUM_REGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
`ifdef ADC_CFG_SOFT_RESET_EN
    localparam logic [IW-1:0] FIRST_IDX = RST_IDX;
`else
    localparam logic [IW-1:0] FIRST_IDX = '0;
`endif
    localparam logic [CW-1:0] TMO_LAST     = CW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RST_GAP_LAST = CW'(RST_WAIT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, issue_idx, err_idx_q, err_idx_d;
    logic [CW-1:0] cnt_q, cnt_d, gap_last;
    logic [31:0]   data_q, data_d, issue_word;
    logic          flag_q, flag_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_comb begin
        if (state_q == GAP) begin
            issue_idx = (idx_q == RST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
            issue_idx = FIRST_IDX;
        end
        issue_word = RST_WORD;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (issue_idx == IW'(k)) begin
                issue_word = cfg_table[32*k +: 32];
            end
        end
        gap_last = (idx_q == RST_IDX) ? RST_GAP_LAST : GAP_LAST;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        flag_d    = 1'b0;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = issue_idx;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                    data_d  = issue_word;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            // Both waits share one counter: WAIT_ACK waits for rdy low, WAIT_DONE for rdy high.
            WAIT_ACK, WAIT_DONE: begin
                if (spi.rdy == (state_q == WAIT_DONE)) begin
                    state_d = (state_q == WAIT_ACK) ? WAIT_DONE : GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ERR;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != gap_last) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ISSUE;
                    idx_d   = issue_idx;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                    data_d  = issue_word;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            flag_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign spi.writ_flag = flag_q;
    assign spi.writ_data = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_idx       = err_idx_q;
endmodule

// File: tb/tb_adc_cfg_seq.sv
// Scoreboard bench for adc_cfg_seq with a behavioural SPI master model.
module tb_adc_cfg_seq;
    localparam int unsigned NR    = 3;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 60;
    localparam int unsigned RWAIT = 64;
    localparam logic [31:0] RWORD = 32'h0000_0081;
    localparam logic [31:0] WA    = 32'hA5A5_0001;
    localparam logic [31:0] WB    = 32'h5A5A_0002;
    localparam logic [31:0] WC    = 32'hC3C3_0003;
`ifdef ADC_CFG_SOFT_RESET_EN
    localparam int SOFT = 1;
`else
    localparam int SOFT = 0;
`endif
    localparam int STUCK_N = SOFT + 2;
    localparam int M_NORMAL = 0, M_NEVER = 1, M_STUCK = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NR*32-1:0] cfg_table = {WC, WB, WA};
    logic             busy, done, err;
    logic [1:0]       err_idx;

    adc_cfg_seq_if ifc();

    adc_cfg_seq #(
        .NUM_REGS(NR), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .RST_WORD(RWORD), .RST_WAIT(RWAIT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_table(cfg_table),
        .spi(ifc), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0, n_flag = 0, n_done = 0, flag_cyc = 0, rise_cyc = 0;
    bit          first_flag = 1'b0, last_rst = 1'b0, prev_rdy = 1'b1;
    int          mode = M_NORMAL, m_flag = 0, dly = 0, low = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI master: drops rdy 2 cycles after a flag, keeps it low 32 cycles.
    initial begin
        ifc.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ifc.rdy = 1'b1;
                dly = 0;
                low = 0;
            end else if (ifc.writ_flag) begin
                m_flag++;
                dly = 2;
                low = 0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0 && mode != M_NEVER) begin
                    ifc.rdy = 1'b0;
                    low = 32;
                end
            end else if (low > 0 && !(mode == M_STUCK && m_flag == STUCK_N)) begin
                low--;
                if (low == 0) ifc.rdy = 1'b1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every flag, checks flag spacing after rdy rises.
    initial forever begin
        logic [31:0] expd;
        @(negedge clk);
        if (rst_n) begin
            if (ifc.rdy && !prev_rdy) rise_cyc = cyc;
            prev_rdy = ifc.rdy;
            if (ifc.writ_flag) begin
                n_flag++;
                flag_cyc = cyc;
                check("flag_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    expd = exp_q.pop_front();
                    check("writ_data", ifc.writ_data, expd);
                    if (!first_flag) check("flag_gap", cyc - rise_cyc, last_rst ? RWAIT + 1 : GAP + 1);
                    first_flag = 1'b0;
                    last_rst = (SOFT != 0) && (expd == RWORD);
                end
            end
            if (done) n_done++;
        end
    end

    task automatic check_reset_vals;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        check("rst_writ_flag", 32'(ifc.writ_flag), 0);
        check("rst_writ_data", ifc.writ_data, 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic expect_words(input int n);
        logic [NR*32-1:0] tbl;
        tbl = cfg_table;
        if (SOFT != 0) exp_q.push_back(RWORD);
        for (int i = 0; i < n; i++) exp_q.push_back(tbl[32*i +: 32]);
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic begin_seq;
        @(posedge clk);
        #1;
        m_flag = 0;
        first_flag = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("flag_latency", 32'(ifc.writ_flag), 1);
        check("err_cleared", 32'(err), 0);
        check("busy_set", 32'(busy), 1);
    endtask

    task automatic pulse_abort;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done != d0) break;
        end
        @(negedge clk);
        check("done_once", n_done - d0, 1);
        check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic wait_err(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (err) break;
        end
        check("err_set", 32'(err), 1);
    endtask

    initial begin
        int f0, d0;
        do_reset();

        // Normal three-word run with a start pulse while busy.
        mode = M_NORMAL;
        f0 = n_flag;
        expect_words(3);
        begin_seq();
        repeat (10) @(posedge clk);
        check("busy_mid", 32'(busy), 1);
        pulse_start();
        wait_done(2000);
        check("flag_count", n_flag - f0, 3 + SOFT);
        check("err_normal", 32'(err), 0);
        check("queue_empty_1", exp_q.size(), 0);

        // Never acknowledged: timeout in WAIT_ACK on the first word.
        do_reset();
        mode = M_NEVER;
        exp_q.push_back((SOFT != 0) ? RWORD : WA);
        begin_seq();
        wait_err(TMO + 100);
        check("tmo_cycles", cyc - flag_cyc, TMO + 2);
        check("err_idx_ack", 32'(err_idx), (SOFT != 0) ? NR : 0);
        check("busy_err", 32'(busy), 0);
        f0 = n_flag;
        repeat (20) @(negedge clk);
        check("no_flag_after_err", n_flag - f0, 0);
        exp_q.push_back((SOFT != 0) ? RWORD : WA);
        begin_seq();
        repeat (5) @(posedge clk);
        pulse_abort();
        check("abort_busy", 32'(busy), 0);
        check("abort_err", 32'(err), 0);
        check("queue_empty_2", exp_q.size(), 0);

        // rdy stuck low after word 1 accepted: timeout in WAIT_DONE.
        do_reset();
        mode = M_STUCK;
        d0 = n_done;
        expect_words(2);
        begin_seq();
        wait_err(1000);
        check("err_idx_done", 32'(err_idx), 1);
        check("busy_stuck", 32'(busy), 0);
        repeat (10) @(negedge clk);
        check("no_done_stuck", n_done - d0, 0);
        check("queue_empty_3", exp_q.size(), 0);

        // Abort during WAIT_DONE of word 1, then a clean restart.
        do_reset();
        mode = M_NORMAL;
        f0 = n_flag;
        d0 = n_done;
        expect_words(2);
        begin_seq();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_flag - f0 >= STUCK_N) break;
        end
        repeat (10) @(posedge clk);
        pulse_abort();
        check("abort_busy_w1", 32'(busy), 0);
        check("abort_err_w1", 32'(err), 0);
        f0 = n_flag;
        repeat (60) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_flag", n_flag - f0, 0);
        check("queue_empty_4", exp_q.size(), 0);
        expect_words(3);
        begin_seq();
        wait_done(2000);
        check("queue_empty_5", exp_q.size(), 0);

        // start and abort together in IDLE: abort wins.
        do_reset();
        f0 = n_flag;
        @(posedge clk);
        #1 begin
            start = 1'b1;
            abort = 1'b1;
        end
        @(posedge clk);
        #1 begin
            start = 1'b0;
            abort = 1'b0;
        end
        check("sa_busy", 32'(busy), 0);
        check("sa_flag", 32'(ifc.writ_flag), 0);
        repeat (20) @(negedge clk);
        check("sa_no_flag", n_flag - f0, 0);

        // Asynchronous reset mid-run.
        do_reset();
        expect_words(3);
        begin_seq();
        repeat (40) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        f0 = n_flag;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);
        check("post_rst_no_flag", n_flag - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
